// File: rtl/reset_sequencer.sv
// Power-on / PLL-lock reset sequencer: lock filter, programmable hold, then staggered release of NUM_CH channels.
// Build option RSTSEQ_SOFT_RST_EN adds soft_rst_req, which restarts the sequence from HOLD without re-filtering lock.
module reset_sequencer #(
  parameter int HOLD_CYCLES    = 10000,
  parameter int NUM_CH         = 3,
  parameter int STAGGER_CYCLES = 256,
  parameter int LOCK_FILTER    = 16,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              RSTb,
  input  logic              pll_lock,
`ifdef RSTSEQ_SOFT_RST_EN
  input  logic              soft_rst_req,
`endif
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              ready,
  output logic [1:0]        state_dbg,
  output logic [7:0]        lock_loss_cnt
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_STAGGER   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LF_LAST    = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              r_lock_p0;
  logic              r_lock_p1;
  logic              w_lock_s;
  logic              w_soft;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_rst_n;
  logic              r_ready;
  logic [7:0]        r_llc;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [NUM_CH-1:0] w_rst_n_nxt;
  logic [NUM_CH-1:0] w_rst_shift;
  logic              w_ready_nxt;
  logic [7:0]        w_llc_nxt;

  // Stage p0/p1: lock synchroniser, deliberately not reset so it is already settled when RSTb rises
  always_ff @(posedge clk) begin
    r_lock_p0 <= pll_lock;
    r_lock_p1 <= r_lock_p0;
  end

  assign w_lock_s = r_lock_p1;

`ifdef RSTSEQ_SOFT_RST_EN
  assign w_soft = soft_rst_req;
`else
  assign w_soft = 1'b0;
`endif

  // Next released pattern: shift a one in from bit 0 so release order is strictly ascending
  assign w_rst_shift = NUM_CH'({r_rst_n, 1'b1});
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_n_nxt = r_rst_n;
    w_ready_nxt = r_ready;
    w_llc_nxt   = r_llc;

    case (r_state)
      S_WAIT_LOCK: begin
        w_rst_n_nxt = '0;
        w_ready_nxt = 1'b0;
        if (!w_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LF_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          w_llc_nxt   = sat_inc8(r_llc);
        end else if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_rst_n_nxt = w_rst_shift;
          if (NUM_CH == 1) begin
            w_state_nxt = S_RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = S_STAGGER;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_STAGGER: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          w_llc_nxt   = sat_inc8(r_llc);
        end else if (w_soft) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
        end else if (r_cnt == STAG_LAST) begin
          w_cnt_nxt   = '0;
          w_rst_n_nxt = w_rst_shift;
          if (&w_rst_shift) begin
            w_state_nxt = S_RUN;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_RUN: begin
        w_rst_n_nxt = '1;
        w_ready_nxt = 1'b1;
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          w_llc_nxt   = sat_inc8(r_llc);
        end else if (w_soft) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_rst_n_nxt = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // Stage p2: sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (!RSTb) begin
      r_state <= S_WAIT_LOCK;
      r_cnt   <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
      r_llc   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_ready <= w_ready_nxt;
      r_llc   <= w_llc_nxt;
    end
  end

  assign rst_n_out     = r_rst_n;
  assign ready         = r_ready;
  assign state_dbg     = r_state;
  assign lock_loss_cnt = r_llc;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timeline-based reference model, literal timing checks and random lock traffic.
// Soft-reset scenarios are compiled in when RSTSEQ_SOFT_RST_EN is defined.
module tb_reset_sequencer;
  localparam int HC = 20;
  localparam int SC = 4;
  localparam int LF = 4;
  localparam int NC = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          RSTb = 1'b0;
  logic          pll_lock = 1'b1;
  logic          soft_rst_req = 1'b0;
  logic [NC-1:0] rst_n_out;
  logic          ready;
  logic [1:0]    state_dbg;
  logic [7:0]    lock_loss_cnt;

  int n_chk = 0;
  int n_err = 0;
  int e = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES(HC), .NUM_CH(NC), .STAGGER_CYCLES(SC), .LOCK_FILTER(LF), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .RSTb(RSTb),
    .pll_lock(pll_lock),
`ifdef RSTSEQ_SOFT_RST_EN
    .soft_rst_req(soft_rst_req),
`endif
    .rst_n_out(rst_n_out),
    .ready(ready),
    .state_dbg(state_dbg),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // Reference model: the sequence is a timeline measured from the edge HOLD was entered
  int            t = 0;
  bit            m_ff1 = 1'b0;
  bit            m_ls = 1'b0;
  bit            m_in_seq = 1'b0;
  int            m_hold = 0;
  int            m_filt = 0;
  int            m_llc = 0;
  logic [NC-1:0] exp_rst = '0;
  logic          exp_ready = 1'b0;
  logic [1:0]    exp_state = 2'd0;
  logic [7:0]    exp_llc = 8'd0;

  function automatic int nrel(input int el);
    int r;
    if (el < HC) return 0;
    r = 1 + (el - HC) / SC;
    return (r > NC) ? NC : r;
  endfunction

  always @(posedge clk) begin
    int  rel_prev;
    int  rel;
    bit  ls_used;
    ls_used  = m_ls;
    rel_prev = m_in_seq ? nrel(t - m_hold) : 0;
    t = t + 1;
    if (!RSTb) begin
      m_in_seq = 1'b0;
      m_filt   = 0;
      m_llc    = 0;
    end else if (!m_in_seq) begin
      if (ls_used) begin
        m_filt = m_filt + 1;
        if (m_filt == LF) begin
          m_in_seq = 1'b1;
          m_hold   = t;
          m_filt   = 0;
        end
      end else begin
        m_filt = 0;
      end
    end else if (!ls_used) begin
      m_in_seq = 1'b0;
      m_filt   = 0;
      if (m_llc < 255) m_llc = m_llc + 1;
    end else if (soft_rst_req && rel_prev >= 1) begin
      m_hold = t;
    end
    m_ls  = m_ff1;
    m_ff1 = pll_lock;

    rel     = m_in_seq ? nrel(t - m_hold) : 0;
    exp_rst = '0;
    for (int i = 0; i < NC; i++) if (i < rel) exp_rst[i] = 1'b1;
    exp_ready = (rel == NC);
    exp_state = !m_in_seq ? 2'd0 : (rel == 0) ? 2'd1 : (rel < NC) ? 2'd2 : 2'd3;
    exp_llc   = 8'(m_llc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk = n_chk + 1;
    if (act !== req) begin
      n_err = n_err + 1;
      $display("FAIL %s at t=%0d: got %0h, required %0h", nm, t, act, req);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] dv, input logic [31:0] mv, input logic [31:0] ev);
    chk(nm, dv, ev);
    chk({nm, "_model"}, mv, ev);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rst_n", 32'(rst_n_out), 32'(exp_rst));
      chk("cyc_ready", 32'(ready), 32'(exp_ready));
      chk("cyc_state", 32'(state_dbg), 32'(exp_state));
      chk("cyc_llc", 32'(lock_loss_cnt), 32'(exp_llc));
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      e = e + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    RSTb = 1'b0;
    adv(1);
    chk_en = 1'b1;
    adv(4);
    lit("rst_rst_n", 32'(rst_n_out), 32'(exp_rst), 32'd0);
    lit("rst_ready", 32'(ready), 32'(exp_ready), 32'd0);
    lit("rst_state", 32'(state_dbg), 32'(exp_state), 32'd0);
    lit("rst_llc", 32'(lock_loss_cnt), 32'(exp_llc), 32'd0);
    RSTb = 1'b1;
    e = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on with lock already stable
    pll_lock = 1'b1;
    do_reset();
    adv(3);  lit("po_e3_state", 32'(state_dbg), 32'(exp_state), 32'd0);
    adv(1);  lit("po_e4_state", 32'(state_dbg), 32'(exp_state), 32'd1);
    adv(19); lit("po_e23_rst", 32'(rst_n_out), 32'(exp_rst), 32'd0);
    adv(1);  lit("po_e24_rst", 32'(rst_n_out), 32'(exp_rst), 32'd1);
             lit("po_e24_state", 32'(state_dbg), 32'(exp_state), 32'd2);
    adv(3);  lit("po_e27_rst", 32'(rst_n_out), 32'(exp_rst), 32'd1);
    adv(1);  lit("po_e28_rst", 32'(rst_n_out), 32'(exp_rst), 32'd3);
    adv(3);  lit("po_e31_ready", 32'(ready), 32'(exp_ready), 32'd0);
    adv(1);  lit("po_e32_rst", 32'(rst_n_out), 32'(exp_rst), 32'd7);
             lit("po_e32_ready", 32'(ready), 32'(exp_ready), 32'd1);
             lit("po_e32_state", 32'(state_dbg), 32'(exp_state), 32'd3);

    // Lock loss in RUN, 10 cycles low
    adv(3);
    pll_lock = 1'b0;
    adv(2);  lit("ll_e37_rst", 32'(rst_n_out), 32'(exp_rst), 32'd7);
    adv(1);  lit("ll_e38_rst", 32'(rst_n_out), 32'(exp_rst), 32'd0);
             lit("ll_e38_ready", 32'(ready), 32'(exp_ready), 32'd0);
             lit("ll_e38_llc", 32'(lock_loss_cnt), 32'(exp_llc), 32'd1);
    adv(7);
    pll_lock = 1'b1;
    adv(25); lit("ll_r25_rst", 32'(rst_n_out), 32'(exp_rst), 32'd0);
    adv(1);  lit("ll_r26_rst", 32'(rst_n_out), 32'(exp_rst), 32'd1);
    adv(8);  lit("ll_r34_rst", 32'(rst_n_out), 32'(exp_rst), 32'd7);
             lit("ll_r34_llc", 32'(lock_loss_cnt), 32'(exp_llc), 32'd1);

    // Lock loss on the edge that would release the last channel
    do_reset();
    adv(29);
    pll_lock = 1'b0;
    adv(2);  lit("se_e31_rst", 32'(rst_n_out), 32'(exp_rst), 32'd3);
    adv(1);  lit("se_e32_rst", 32'(rst_n_out), 32'(exp_rst), 32'd0);
             lit("se_e32_ready", 32'(ready), 32'(exp_ready), 32'd0);
             lit("se_e32_llc", 32'(lock_loss_cnt), 32'(exp_llc), 32'd1);
    adv(3);
    pll_lock = 1'b1;
    adv(10);

    // One-cycle glitch while filtering lock
    do_reset();
    adv(1);
    pll_lock = 1'b0;
    adv(1);
    pll_lock = 1'b1;
    adv(25); lit("gl_e27_rst", 32'(rst_n_out), 32'(exp_rst), 32'd0);
    adv(1);  lit("gl_e28_rst", 32'(rst_n_out), 32'(exp_rst), 32'd1);
             lit("gl_e28_llc", 32'(lock_loss_cnt), 32'(exp_llc), 32'd0);

`ifdef RSTSEQ_SOFT_RST_EN
    // Soft reset pulse in RUN re-enters HOLD
    do_reset();
    adv(35);
    soft_rst_req = 1'b1;
    adv(1);
    soft_rst_req = 1'b0;
    lit("sr_rst", 32'(rst_n_out), 32'(exp_rst), 32'd0);
    lit("sr_state", 32'(state_dbg), 32'(exp_state), 32'd1);
    lit("sr_llc", 32'(lock_loss_cnt), 32'(exp_llc), 32'd0);
    adv(19); lit("sr_p19_rst", 32'(rst_n_out), 32'(exp_rst), 32'd0);
    adv(1);  lit("sr_p20_rst", 32'(rst_n_out), 32'(exp_rst), 32'd1);
    // Soft reset pulse in HOLD is ignored
    do_reset();
    adv(10);
    soft_rst_req = 1'b1;
    adv(1);
    soft_rst_req = 1'b0;
    adv(13); lit("srh_e24_rst", 32'(rst_n_out), 32'(exp_rst), 32'd1);
`endif

    // Random lock traffic, occasional RSTb pulses and soft requests
    do_reset();
    for (int s = 0; s < 80; s++) begin
      int hi;
      hi = int'($urandom_range(1, 60));
      pll_lock = 1'b1;
      for (int c = 0; c < hi; c++) begin
`ifdef RSTSEQ_SOFT_RST_EN
        soft_rst_req = ($urandom_range(0, 39) == 0);
`endif
        adv(1);
      end
      soft_rst_req = 1'b0;
      pll_lock = 1'b0;
      adv(int'($urandom_range(1, 4)));
      if ($urandom_range(0, 9) == 0) begin
        RSTb = 1'b0;
        adv(int'($urandom_range(1, 3)));
        RSTb = 1'b1;
      end
    end

    // Saturating lock-loss counter
    do_reset();
    pll_lock = 1'b0;
    adv(3);
    for (int k = 1; k <= 300; k++) begin
      pll_lock = 1'b1;
      adv(8);
      pll_lock = 1'b0;
      adv(3);
      if (k == 100) lit("sat_100", 32'(lock_loss_cnt), 32'(exp_llc), 32'd100);
    end
    adv(3);
    lit("sat_255", 32'(lock_loss_cnt), 32'(exp_llc), 32'd255);
    RSTb = 1'b0;
    adv(1);
    lit("sat_clr", 32'(lock_loss_cnt), 32'(exp_llc), 32'd0);
    RSTb = 1'b1;
    adv(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on and PLL-lock reset sequencer for the iCE40 top levels. It replaces the fixed 10000-cycle reset counter. It waits for a filtered PLL lock, then holds reset for a programmable time, then releases NUM_CH active-low reset channels in staggered order (for example: PLL-domain glue, SDR core, SPI/PWM). It re-asserts all channels on lock loss and counts those events for debug.

Parameters:
HOLD_CYCLES, 10000, cycles that reset is held after lock is accepted; minimum 1
NUM_CH, 3, number of reset output channels; minimum 1
STAGGER_CYCLES, 256, cycles between successive channel releases; minimum 1
LOCK_FILTER, 16, consecutive synchronised lock-high cycles required; minimum 1
CNT_W, 16, shared counter width; must be at least clog2 of max(HOLD_CYCLES, STAGGER_CYCLES, LOCK_FILTER)+1

Ports:
clk  in  1  system clock (PLL output)
RSTb  in  1  synchronous active-low reset/request; low forces all outputs to reset
pll_lock  in  1  PLL LOCK pin, asynchronous to clk
rst_n_out  out  NUM_CH  active-low resets; bit 0 is released first
ready  out  1  high once all channels are released
state_dbg  out  2  current state: 0=WAIT_LOCK, 1=HOLD, 2=STAGGER, 3=RUN
lock_loss_cnt  out  8  lock-loss events seen since RSTb, saturating

Behaviour:
- Reset is synchronous and active-low on RSTb. Every output is registered.
- While RSTb is low, at each clk edge:
  - rst_n_out = all 0, ready = 0, lock_loss_cnt = 0.
  - state = WAIT_LOCK, and all counters are cleared.
- pll_lock passes through a 2-FF synchroniser that is not reset; its output is lock_s.
- WAIT_LOCK:
  - filter counter increments on each edge where lock_s = 1 and clears to 0 when lock_s = 0.
  - When lock_s = 1 and the counter equals LOCK_FILTER-1, go to HOLD and clear the counter.
- HOLD:
  - counter increments each edge.
  - When it equals HOLD_CYCLES-1, go to STAGGER and set rst_n_out[0] = 1 on that edge.
  - If NUM_CH = 1, go directly to RUN instead, with ready = 1 on the same edge.
- STAGGER:
  - counter counts 0..STAGGER_CYCLES-1.
  - On wrap, release the next channel index (rst_n_out bit i = 1).
  - On the edge that releases channel NUM_CH-1, go to RUN and set ready = 1.
  - Released bits stay high.
- RUN: holds. ready = 1 and rst_n_out = all 1.
- Timing with lock stable high before RSTb rises; edge 1 is the first edge with RSTb = 1:
  - rst_n_out[0] rises at edge LOCK_FILTER+HOLD_CYCLES.
  - channel i rises i*STAGGER_CYCLES edges later.
  - ready rises together with the last channel.
- Lock loss (lock_s = 0 in HOLD, STAGGER or RUN):
  - On the next edge: rst_n_out = all 0, ready = 0, state = WAIT_LOCK, counters cleared.
  - lock_loss_cnt increments, saturating at 255.
- Simultaneous events:
  - Lock loss on the same edge as a channel release: lock loss wins, and no bit is released.
  - RSTb low overrides everything.
- A glitch in WAIT_LOCK restarts the filter from 0. A glitch in WAIT_LOCK is not counted as a lock loss.
- RSTb low mid-sequence behaves exactly as power-on: lock_loss_cnt clears and the sequence restarts once RSTb is high.
- Reset release order is strictly ascending by bit index. Assertion is simultaneous on all bits.

Optional Feature:
RSTSEQ_SOFT_RST_EN
- Defined:
  - Adds input soft_rst_req (1 bit, synchronous to clk), for example from an SPI control register.
  - A 1-cycle high pulse in STAGGER or RUN, on the next edge, sets rst_n_out = all 0, ready = 0, and re-enters HOLD with the counter cleared. The lock filter is skipped.
  - The pulse does not change lock_loss_cnt.
  - The pulse is ignored in WAIT_LOCK and HOLD.
  - If lock loss occurs on the same edge, lock loss wins and goes to WAIT_LOCK.
- Undefined: the port is absent and behaviour is the base behaviour above.

Test Plan:
All scenarios use HOLD_CYCLES=20, STAGGER_CYCLES=4, LOCK_FILTER=4, NUM_CH=3.
- Power-on: pll_lock high and RSTb low for 5 cycles, then high -> all outputs 0 during reset. rst_n_out = 001 at edge 24, 011 at edge 28, 111 at edge 32. ready = 1 at edge 32. state_dbg sequence is 0,1,2,3.
- Lock glitch in filter: lock low for 1 cycle at edge 3 -> filter restarts. rst_n_out[0] rises 4 edges (lock_s delay plus filter) later than in the power-on case. lock_loss_cnt = 0.
- Lock loss in RUN: drop pll_lock for 10 cycles -> rst_n_out = 000 and ready = 0 by 3 edges after the pin falls (2 synchroniser + 1). lock_loss_cnt = 1. After lock returns, the full sequence repeats with the power-on timing offsets.
- Lock loss on the same edge as the channel 2 release -> rst_n_out never shows 111, and the next edge shows 000.
- Saturation: force 300 lock-loss events -> lock_loss_cnt = 255. Then RSTb low -> lock_loss_cnt = 0.
- With RSTSEQ_SOFT_RST_EN defined: soft_rst_req pulse in RUN -> next edge rst_n_out = 000 and state_dbg = 1. rst_n_out[0] rises 20 edges after the pulse. lock_loss_cnt is unchanged.
